// File: rtl/alu_result_stage_pkg.sv
// Shared encodings for the ALU result stage.
//   alu_cmd_e : ALU command codes carried alongside each result
//   state_e   : skid-buffer occupancy
//   is_addsub : true for commands whose overflow bit is meaningful
package alu_result_stage_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_SUB  = 3'b001,
    CMD_AND  = 3'b010,
    CMD_OR   = 3'b011,
    CMD_XOR  = 3'b100,
    CMD_SLT  = 3'b101,
    CMD_NOR  = 3'b110,
    CMD_NAND = 3'b111
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  function automatic logic is_addsub(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk, reset_n : clock, synchronous active-low reset
//   inc          : count one event this cycle
//   clr          : clear; an inc in the same cycle wins and leaves count = 1
//   count        : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc,
  input  logic            clr,
  output logic [CNTW-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      count <= '0;
    else if (inc)
      count <= clr ? CNTW'(1) : ((&count) ? count : count + 1'b1);
    else if (clr)
      count <= '0;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU adder/subtracter.
// Captures result + flags + cmd + tag and hands them on with valid/ready,
// using a main/skid register pair so back-pressure never loses an entry.
// Also keeps a sticky overflow flag and a saturating overflow counter.
//   in_*        : ALU result side (in_ready registered, independent of out_ready)
//   out_*       : writeback/flag consumer side, stable while stalled
//   clr_sticky  : clear sticky_ovf / ovf_count (a same-cycle event wins)
//   sticky_ovf  : overflow seen since last clear
//   ovf_count   : saturating count of ADD/SUB overflow events
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carryout,
  input  logic             in_overflow,
  input  logic             in_zero,
  input  logic [2:0]       in_cmd,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [2:0]       out_cmd,
  output logic [TAGW-1:0]  out_tag,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNTW-1:0]  ovf_count
);

  localparam int PW = WIDTH + 6 + TAGW;

  state_e          state_q, state_nx;
  logic            rdy_q;
  logic [PW-1:0]   main_q, skid_q, in_pl;
  logic            in_fire, out_fire, ovf_ev;
  logic            ld_main_in, ld_main_skid, ld_skid;

  assign in_pl    = {in_result, in_carryout, in_overflow, in_zero, in_cmd, in_tag};
  assign in_fire  = in_valid & rdy_q;
  assign out_fire = out_valid & out_ready;
  assign ovf_ev   = in_fire & in_overflow & is_addsub(in_cmd);

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign {out_result, out_carryout, out_overflow, out_zero, out_cmd, out_tag} = main_q;

  always_comb begin
    state_nx     = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: if (in_fire) begin
        state_nx   = ST_ONE;
        ld_main_in = 1'b1;
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_nx = ST_FULL;
          ld_skid  = 1'b1;
        end else if (out_fire) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_FULL: if (out_fire) begin
        state_nx     = ST_ONE;
        ld_main_skid = 1'b1;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  // in_ready is precomputed from next state so it is a pure flop output
  // and never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_nx;
      rdy_q   <= (state_nx != ST_FULL);
      if (ld_main_in)   main_q <= in_pl;
      if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= in_pl;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      sticky_ovf <= 1'b0;
    else if (ovf_ev)
      sticky_ovf <= 1'b1;
    else if (clr_sticky)
      sticky_ovf <= 1'b0;
  end

  sat_counter #(.CNTW(CNTW)) u_ovf_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ovf_ev),
    .clr     (clr_sticky),
    .count   (ovf_count)
  );

endmodule
